// File: rtl/traffic_phase_sequencer.sv
// Tick-driven traffic phase sequencer RED->YELLOW->GREEN(->FLASH)->RED with a synchronised
// pedestrian request that can shorten GREEN. Define TPS_FLASH_EN to include the FLASH phase.
module traffic_phase_sequencer #(
  parameter int RED_TICKS    = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int GREEN_TICKS  = 4,
  parameter int FLASH_TICKS  = 3,
  parameter int MIN_GREEN    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       flash_tick,
  input  logic       hold,
  input  logic       req_btn,
  output logic [1:0] state,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic [3:0] remaining,
  output logic       req_pending,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_YELLOW = 2'd1,
    S_GREEN  = 2'd2,
    S_FLASH  = 2'd3
  } phase_t;

  localparam logic [3:0] RED_LOAD    = 4'(RED_TICKS - 1);
  localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] FLASH_LOAD  = 4'(FLASH_TICKS - 1);
  localparam logic [4:0] MIN_GREEN_W = 5'(MIN_GREEN);

  phase_t     cur;
  phase_t     succ;
  logic [3:0] elapsed;
  logic [3:0] load_val;
  logic       flash_phase;
  logic       sync1;
  logic       sync2;
  logic       sync_prev;
  logic       req_edge;
  logic       adv;
  logic       early_exit;
  logic       go;
  logic       flash_toggle;

  // Request path: 2-FF synchroniser, then one extra stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= req_btn;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign req_edge = sync2 & ~sync_prev;

  always_comb begin
    adv          = tick & ~hold;
    early_exit   = (cur == S_GREEN) && req_pending &&
                   (({1'b0, elapsed} + 5'd1) >= MIN_GREEN_W);
    go           = adv && ((remaining == 4'd0) || early_exit);
    flash_toggle = ~hold & flash_tick & (cur == S_FLASH) & ~go;
    succ         = S_RED;
    case (cur)
      S_RED:    succ = S_YELLOW;
      S_YELLOW: succ = S_GREEN;
`ifdef TPS_FLASH_EN
      S_GREEN:  succ = S_FLASH;
`else
      S_GREEN:  succ = S_RED;
`endif
      default:  succ = S_RED;
    endcase
    load_val = RED_LOAD;
    case (succ)
      S_RED:    load_val = RED_LOAD;
      S_YELLOW: load_val = YELLOW_LOAD;
      S_GREEN:  load_val = GREEN_LOAD;
      default:  load_val = FLASH_LOAD;
    endcase
  end

  // Phase FSM; lamps are computed from the entered phase so they change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= S_RED;
      remaining   <= RED_LOAD;
      elapsed     <= 4'd0;
      flash_phase <= 1'b0;
      lamp_red    <= 1'b1;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
      req_pending <= 1'b0;
      phase_done  <= 1'b0;
    end else begin
      phase_done <= go;
      if (go) begin
        cur         <= succ;
        remaining   <= load_val;
        elapsed     <= 4'd0;
        flash_phase <= (succ == S_FLASH);
        lamp_red    <= (succ == S_RED);
        lamp_yellow <= (succ == S_YELLOW);
        lamp_green  <= (succ == S_GREEN) || (succ == S_FLASH);
      end else begin
        if (adv && (remaining != 4'd0)) begin
          remaining <= remaining - 4'd1;
          elapsed   <= elapsed + 4'd1;
        end
        if (flash_toggle) begin
          flash_phase <= ~flash_phase;
          lamp_green  <= ~flash_phase;
        end
      end
      // Serving the request on GREEN exit wins over an edge landing in the same cycle.
      if (go && (cur == S_GREEN)) begin
        req_pending <= 1'b0;
      end else if (req_edge) begin
        req_pending <= 1'b1;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer (default parameters); adapts its
// expected phase tables to whether TPS_FLASH_EN is defined.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       flash_tick = 1'b0;
  logic       hold = 1'b0;
  logic       req_btn = 1'b0;
  logic [1:0] state;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic [3:0] remaining;
  logic       req_pending;
  logic       phase_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle phase tables with tick high every cycle, index 0 = RED entry.
`ifdef TPS_FLASH_EN
  localparam int PERIOD = 13;
  localparam int PD_PER_PERIOD = 4;
  int cyc_st  [PERIOD] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3};
  int cyc_rem [PERIOD] = '{3, 2, 1, 0, 1, 0, 3, 2, 1, 0, 2, 1, 0};
  int cyc_pd  [PERIOD] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
  localparam int EXIT_ST  = 3;
  localparam int EXIT_REM = 2;
`else
  localparam int PERIOD = 10;
  localparam int PD_PER_PERIOD = 3;
  int cyc_st  [PERIOD] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
  int cyc_rem [PERIOD] = '{3, 2, 1, 0, 1, 0, 3, 2, 1, 0};
  int cyc_pd  [PERIOD] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
  localparam int EXIT_ST  = 0;
  localparam int EXIT_REM = 3;
`endif

  traffic_phase_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .flash_tick  (flash_tick),
    .hold        (hold),
    .req_btn     (req_btn),
    .state       (state),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .remaining   (remaining),
    .req_pending (req_pending),
    .phase_done  (phase_done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick       = 1'b0;
    flash_tick = 1'b0;
    hold       = 1'b0;
    req_btn    = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (remaining !== 4'd3) begin
      n_fail++; $display("FAIL reset_remaining: got %0d expected 3", remaining);
    end
    n_checks++;
    if ({lamp_red, lamp_yellow, lamp_green} !== 3'b100) begin
      n_fail++; $display("FAIL reset_lamps: got %b expected 100", {lamp_red, lamp_yellow, lamp_green});
    end
    n_checks++;
    if ({req_pending, phase_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {req_pending, phase_done});
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({state, remaining, phase_done} !== {2'd0, 4'd3, 1'b0}) begin
      n_fail++; $display("FAIL reset_idle: got %0d/%0d/%0d expected 0/3/0", state, remaining, phase_done);
    end
  endtask

  task automatic test_cycle();
    logic [9:0] got_v;
    logic [9:0] exp_v;
    int idx;
    int pd_count;
    apply_reset();
    tick       = 1'b1;
    flash_tick = 1'b0;
    pd_count   = 0;
    for (int i = 1; i <= 2 * PERIOD; i++) begin
      step();
      idx   = i % PERIOD;
      got_v = {state, remaining, phase_done, lamp_red, lamp_yellow, lamp_green};
      exp_v = {2'(cyc_st[idx]), 4'(cyc_rem[idx]), cyc_pd[idx] != 0,
               cyc_st[idx] == 0, cyc_st[idx] == 1, cyc_st[idx] >= 2};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL cycle[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      if ((i <= PERIOD) && phase_done) pd_count++;
    end
    n_checks++;
    if (pd_count != PD_PER_PERIOD) begin
      n_fail++; $display("FAIL phase_done_count: got %0d expected %0d", pd_count, PD_PER_PERIOD);
    end
  endtask

  task automatic test_req_in_red();
    int ex_st  [8] = '{0, 0, 0, 1, 1, 2, 2, EXIT_ST};
    int ex_rem [8] = '{2, 1, 0, 1, 0, 3, 2, EXIT_REM};
    int ex_req [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    apply_reset();
    req_btn = 1'b1;
    step();
    step();
    n_checks++;
    if (req_pending !== 1'b0) begin
      n_fail++; $display("FAIL req_sync_latency: got %b expected 0", req_pending);
    end
    step();
    n_checks++;
    if (req_pending !== 1'b1) begin
      n_fail++; $display("FAIL req_captured: got %b expected 1", req_pending);
    end
    tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({state, remaining, req_pending} !== {2'(ex_st[i]), 4'(ex_rem[i]), ex_req[i] != 0}) begin
        n_fail++;
        $display("FAIL req_red_seq[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 i, state, remaining, req_pending, ex_st[i], ex_rem[i], ex_req[i]);
      end
    end
  endtask

  task automatic test_req_in_green();
    apply_reset();
    run_ticks(6);
    tick    = 1'b0;
    req_btn = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if ({state, remaining, req_pending} !== {2'd2, 4'd3, 1'b1}) begin
      n_fail++; $display("FAIL green_req_wait: got %0d/%0d/%0d expected 2/3/1", state, remaining, req_pending);
    end
    tick = 1'b1;
    step();
    n_checks++;
    if ({state, remaining, req_pending} !== {2'd2, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL green_min_hold: got %0d/%0d/%0d expected 2/2/1", state, remaining, req_pending);
    end
    step();
    n_checks++;
    if ({state, remaining, req_pending, phase_done} !== {2'(EXIT_ST), 4'(EXIT_REM), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL green_early_exit: got %0d/%0d/%0d/%0d expected %0d/%0d/0/1",
               state, remaining, req_pending, phase_done, EXIT_ST, EXIT_REM);
    end
  endtask

  task automatic test_exit_priority();
    apply_reset();
    run_ticks(7);
    req_btn = 1'b1;
    step();
    step();
    n_checks++;
    if ({state, remaining, req_pending} !== {2'd2, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL prio_pre_exit: got %0d/%0d/%0d expected 2/0/0", state, remaining, req_pending);
    end
    step();
    n_checks++;
    if ({state, req_pending} !== {2'(EXIT_ST), 1'b0}) begin
      n_fail++; $display("FAIL prio_exit_wins: got %0d/%0d expected %0d/0", state, req_pending, EXIT_ST);
    end
    step();
    n_checks++;
    if (req_pending !== 1'b0) begin
      n_fail++; $display("FAIL prio_no_late_set: got %b expected 0", req_pending);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    run_ticks(4);
    hold    = 1'b1;
    req_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({state, remaining, phase_done} !== {2'd1, 4'd1, 1'b0}) begin
        n_fail++; $display("FAIL hold_freeze[%0d]: got %0d/%0d/%0d expected 1/1/0", i, state, remaining, phase_done);
      end
    end
    n_checks++;
    if (req_pending !== 1'b1) begin
      n_fail++; $display("FAIL hold_req_capture: got %b expected 1", req_pending);
    end
    hold = 1'b0;
    step();
    n_checks++;
    if ({state, remaining} !== {2'd1, 4'd0}) begin
      n_fail++; $display("FAIL hold_resume1: got %0d/%0d expected 1/0", state, remaining);
    end
    step();
    n_checks++;
    if ({state, remaining, phase_done} !== {2'd2, 4'd3, 1'b1}) begin
      n_fail++; $display("FAIL hold_resume2: got %0d/%0d/%0d expected 2/3/1", state, remaining, phase_done);
    end
  endtask

`ifdef TPS_FLASH_EN
  task automatic test_flash();
    int ft_pat [5] = '{1, 0, 1, 0, 1};
    int lg_exp [5] = '{0, 0, 1, 1, 0};
    apply_reset();
    run_ticks(9);
    flash_tick = 1'b1;
    step();
    n_checks++;
    if ({state, lamp_red, lamp_yellow, lamp_green} !== {2'd3, 3'b001}) begin
      n_fail++; $display("FAIL flash_entry: got %0d/%b expected 3/001", state, {lamp_red, lamp_yellow, lamp_green});
    end
    tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flash_tick = (ft_pat[i] != 0);
      step();
      n_checks++;
      if ({state, lamp_green} !== {2'd3, lg_exp[i] != 0}) begin
        n_fail++; $display("FAIL flash_toggle[%0d]: got %0d/%b expected 3/%0d", i, state, lamp_green, lg_exp[i]);
      end
    end
    hold       = 1'b1;
    flash_tick = 1'b1;
    step();
    n_checks++;
    if ({state, lamp_green} !== {2'd3, 1'b0}) begin
      n_fail++; $display("FAIL flash_hold: got %0d/%b expected 3/0", state, lamp_green);
    end
    hold       = 1'b0;
    flash_tick = 1'b0;
    run_ticks(3);
    n_checks++;
    if ({state, remaining, lamp_red, lamp_yellow, lamp_green} !== {2'd0, 4'd3, 3'b100}) begin
      n_fail++; $display("FAIL flash_to_red: got %0d/%0d/%b expected 0/3/100",
                         state, remaining, {lamp_red, lamp_yellow, lamp_green});
    end
  endtask
`else
  task automatic test_no_flash();
    apply_reset();
    flash_tick = 1'b1;
    tick       = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      n_checks++;
      if ({state, lamp_green} !== {2'(cyc_st[i % PERIOD]), cyc_st[i % PERIOD] == 2}) begin
        n_fail++; $display("FAIL no_flash[%0d]: got %0d/%b expected %0d", i, state, lamp_green, cyc_st[i % PERIOD]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    apply_reset();
    run_ticks(6);
    tick    = 1'b0;
    req_btn = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if ({state, req_pending} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL mid_pre: got %0d/%0d expected 2/1", state, req_pending);
    end
    #2;
    reset   = 1'b1;
    req_btn = 1'b0;
    #1;
    n_checks++;
    if ({state, remaining, lamp_red, lamp_yellow, lamp_green, req_pending, phase_done} !==
        {2'd0, 4'd3, 3'b100, 2'b00}) begin
      n_fail++; $display("FAIL mid_async_reset: got %0d/%0d/%b/%0d expected 0/3/100/0",
                         state, remaining, {lamp_red, lamp_yellow, lamp_green}, req_pending);
    end
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({state, remaining, lamp_red, req_pending} !== {2'd0, 4'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mid_after_release: got %0d/%0d/%0d/%0d expected 0/3/1/0",
                         state, remaining, lamp_red, req_pending);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_req_in_red();
    test_req_in_green();
    test_exit_priority();
    test_hold();
`ifdef TPS_FLASH_EN
    test_flash();
`else
    test_no_flash();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
